// File: rtl/sram_fifo_ctrl.sv
// Purpose: valid/ready FIFO wrapped around a 1w1r SRAM macro, plus a 2-entry FWFT output buffer.
// Latency: a word pushed into an empty FIFO shows on out_valid two cycles after acceptance.
// Backpressure: in_ready drops only when the SRAM is full; read issue stalls once the output buffer plus any in-flight read reach 2 words.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int DEPTH     = 1 << ADDR_WIDTH,
    localparam int CNT_WIDTH = ADDR_WIDTH + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  mem_csb0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    output logic                  mem_csb1,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    input  logic [DATA_WIDTH-1:0] mem_dout1
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   sram_cnt;
    logic [ADDR_WIDTH:0]   sram_cnt_nxt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            obuf_cnt;
    logic [1:0]            obuf_cnt_nxt;
    logic                  push;
    logic                  pop;
    logic                  issue;

    // in_ready looks only at registered SRAM occupancy, never at out_ready.
    assign in_ready  = rst_n & (sram_cnt < DEPTH_C);
    assign push      = in_valid & in_ready;
    assign out_valid = (obuf_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    // A pop frees a slot this cycle, so a read may be issued even with the buffer committed.
    assign issue     = (sram_cnt != '0) & (((obuf_cnt + {1'b0, inflight}) < 2'd2) | pop);

    assign mem_csb0  = ~push;
    assign mem_addr0 = wptr;
    assign mem_din0  = in_data;
    assign mem_csb1  = ~issue;
    assign mem_addr1 = rptr;

    assign out_data  = obuf[head];
    // An in-flight read always lands in a free slot, so obuf_cnt is at most 1 here.
    assign tail      = head ^ obuf_cnt[0];

    // Next occupancies of the SRAM and the output buffer.
    always_comb begin
        sram_cnt_nxt = sram_cnt;
        obuf_cnt_nxt = obuf_cnt;
        if (push && !issue) begin
            sram_cnt_nxt = sram_cnt + 1'b1;
        end else if (!push && issue) begin
            sram_cnt_nxt = sram_cnt - 1'b1;
        end
        if (inflight && !pop) begin
            obuf_cnt_nxt = obuf_cnt + 1'b1;
        end else if (!inflight && pop) begin
            obuf_cnt_nxt = obuf_cnt - 1'b1;
        end
    end

    // Pointer, occupancy and registered count state; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
            head     <= 1'b0;
            obuf_cnt <= 2'd0;
            count    <= '0;
        end else begin
            if (push)  wptr <= wptr + 1'b1;
            if (issue) rptr <= rptr + 1'b1;
            if (pop)   head <= ~head;
            sram_cnt <= sram_cnt_nxt;
            inflight <= issue;
            obuf_cnt <= obuf_cnt_nxt;
            count    <= CNT_WIDTH'(sram_cnt_nxt) + CNT_WIDTH'(issue) + CNT_WIDTH'(obuf_cnt_nxt);
        end
    end

    // Capture macro read data exactly one cycle after the read was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
        end else if (inflight) begin
            obuf[tail] <= mem_dout1;
        end
    end

`ifndef SYNTHESIS
    // Reads and writes can never collide on one address because of the occupancy gating.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!push || !issue || (wptr != rptr));
        end
    end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Purpose: randomized and directed checks of sram_fifo_ctrl against a queue-based reference model.
// Latency: the model treats a word as visible once two clock edges have passed since its acceptance.
// Backpressure: the bench drives random in_valid/out_ready and tracks accepted/popped words by handshake.
module tb_sram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [6:0]  count;
    logic        mem_csb0;
    logic [4:0]  mem_addr0;
    logic [31:0] mem_din0;
    logic        mem_csb1;
    logic [4:0]  mem_addr1;
    logic [31:0] mem_dout1 = 'x;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;
    int spurious = 0;

    logic [31:0] q_d[$];
    int          q_t[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic [31:0] mem [32];

    sram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .mem_csb0(mem_csb0), .mem_addr0(mem_addr0), .mem_din0(mem_din0),
        .mem_csb1(mem_csb1), .mem_addr1(mem_addr1), .mem_dout1(mem_dout1)
    );

    always #5 clk = ~clk;

    // Macro model: controls sampled for the coming posedge, write and read data at the following negedge,
    // read data turns X shortly after the next posedge.
    initial begin : sram_model
        logic        w_en, r_en;
        logic [4:0]  w_a, r_a;
        logic [31:0] w_d;
        @(negedge clk);
        forever begin
            #3;
            w_en = !mem_csb0; w_a = mem_addr0; w_d = mem_din0;
            r_en = !mem_csb1; r_a = mem_addr1;
            @(posedge clk);
            #1 mem_dout1 = 'x;
            @(negedge clk);
            if (w_en) mem[w_a] = w_d;
            #1;
            if (r_en) mem_dout1 = mem[r_a];
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic model_valid();
        if (q_d.size() == 0) return 1'b0;
        return (cyc - q_t[0]) >= 2;
    endfunction

    task automatic model_clear();
        q_d.delete(); q_t.delete(); got.delete(); exp_q.delete();
    endtask

    // One clock: record handshakes just before the edge, update the model after it. Starts and ends at negedge.
    task automatic step();
        logic p, o;
        logic [31:0] d;
        #1;
        p = in_valid && in_ready;
        o = out_valid && out_ready;
        d = in_data;
        if (o) begin
            if (q_d.size() > 0) begin
                got.push_back(out_data);
                exp_q.push_back(q_d[0]);
            end else begin
                spurious++;
            end
        end
        @(posedge clk);
        cyc++;
        if (o && q_d.size() > 0) begin
            void'(q_d.pop_front());
            void'(q_t.pop_front());
        end
        if (p) begin
            q_d.push_back(d);
            q_t.push_back(cyc);
            acc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (count !== 7'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (mem_csb0 !== 1'b1 || mem_csb1 !== 1'b1) begin bad++; $display("FAIL rst_csb got=%b%b want=11", mem_csb0, mem_csb1); end
        total++; if (mem_addr0 !== 5'd0 || mem_addr1 !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d/%0d want=0/0", mem_addr0, mem_addr1); end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        step(); step();
        total++; if (count !== 7'd0) begin bad++; $display("FAIL idle_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
        total++; if (mem_csb0 !== 1'b1 || mem_csb1 !== 1'b1) begin bad++; $display("FAIL idle_csb got=%b%b want=11", mem_csb0, mem_csb1); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        #1;
        total++; if (mem_csb0 !== 1'b0 || mem_addr0 !== 5'd0 || mem_din0 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_wr csb0=%b addr0=%0d din0=%h want 0/0/deadbeef", mem_csb0, mem_addr0, mem_din0); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (mem_csb1 !== 1'b0 || mem_addr1 !== 5'd0) begin
            bad++; $display("FAIL single_rd csb1=%b addr1=%0d want 0/0", mem_csb1, mem_addr1); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_head valid=%b data=%h want 1/deadbeef", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (count !== 7'd0) begin bad++; $display("FAIL single_count got=%0d want=0", count); end
        total++; if (got.size() != 1 || got[0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_pop got_n=%0d want 1 word deadbeef", got.size()); end
        model_clear();
    endtask

    task automatic test_fill();
        int a0;
        a0 = acc;
        out_ready = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        #1;
        total++; if (acc - a0 != 34) begin bad++; $display("FAIL fill_accepted got=%0d want=34", acc - a0); end
        total++; if (count !== 7'd34) begin bad++; $display("FAIL fill_count got=%0d want=34", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b1 || $isunknown(out_data)) begin
            bad++; $display("FAIL fill_head valid=%b data=%h want 1/known", out_valid, out_data); end
        got.delete(); exp_q.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 100 && got.size() < 34; n++) step();
        out_ready = 1'b0;
        total++; if (got.size() != 34) begin bad++; $display("FAIL fill_drain_n got=%0d want=34", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== 32'(i)) begin bad++; $display("FAIL fill_order idx=%0d got=%0d want=%0d", i, got[i], i); end
        end
        total++; if (count !== 7'd0) begin bad++; $display("FAIL fill_end_count got=%0d want=0", count); end
        model_clear();
    endtask

    task automatic test_stream();
        int a0, pushed, first, last, n_before;
        a0 = acc; pushed = 0; first = -1; last = -1;
        out_ready = 1'b1;
        for (int n = 0; n < 400 && got.size() < 200; n++) begin
            in_valid = (pushed < 200);
            in_data  = 32'(1000 + pushed);
            if (in_valid && in_ready) pushed++;
            n_before = got.size();
            step();
            if (got.size() > n_before) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            total++; if (count !== 7'(q_d.size())) begin bad++; $display("FAIL stream_count got=%0d want=%0d", count, q_d.size()); end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (acc - a0 != 200) begin bad++; $display("FAIL stream_accepted got=%0d want=200", acc - a0); end
        total++; if (got.size() != 200) begin bad++; $display("FAIL stream_popped got=%0d want=200", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== 32'(1000 + i)) begin bad++; $display("FAIL stream_data idx=%0d got=%0d want=%0d", i, got[i], 1000 + i); end
        end
        total++; if (last - first != 199) begin bad++; $display("FAIL stream_rate span=%0d want=199", last - first); end
        model_clear();
    endtask

    task automatic test_random();
        int pushed, pv, pr, errs;
        logic [31:0] g, e;
        pushed = 0; pv = 70; pr = 60; errs = 0;
        for (int n = 0; n < 60000; n++) begin
            if (pushed >= 10000 && q_d.size() == 0) break;
            if (n % 500 == 0) begin pv = $urandom_range(20, 95); pr = $urandom_range(20, 95); end
            in_valid  = (pushed < 10000) && ($urandom_range(0, 99) < pv);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < pr);
            if (in_valid && in_ready) pushed++;
            total++; if (count !== 7'(q_d.size())) begin bad++; errs++;
                if (errs < 20) $display("FAIL rand_count cyc=%0d got=%0d want=%0d", cyc, count, q_d.size()); end
            total++; if (out_valid !== model_valid()) begin bad++; errs++;
                if (errs < 20) $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, out_valid, model_valid()); end
            total++; if ((q_d.size() < 32 && in_ready !== 1'b1) || (q_d.size() >= 34 && in_ready !== 1'b0)) begin bad++; errs++;
                if (errs < 20) $display("FAIL rand_in_ready cyc=%0d got=%b held=%0d", cyc, in_ready, q_d.size()); end
            step();
            while (got.size() > 0) begin
                g = got.pop_front(); e = exp_q.pop_front();
                total++; if (g !== e) begin bad++; errs++;
                    if (errs < 20) $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, g, e); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (pushed != 10000 || q_d.size() != 0) begin bad++;
            $display("FAIL rand_done pushed=%0d left=%0d want 10000/0", pushed, q_d.size()); end
        total++; if (spurious != 0) begin bad++; $display("FAIL rand_spurious got=%0d want=0", spurious); end
        model_clear();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1; in_data = 32'hA00 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        #1;
        total++; if (mem_csb1 !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL mid_issue csb1=%b valid=%b want 0/1", mem_csb1, out_valid); end
        step();
        out_ready = 1'b0;
        total++; if (count !== 7'd20) begin bad++; $display("FAIL mid_pre_count got=%0d want=20", count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || count !== 7'd0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_async valid=%b count=%0d in_ready=%b want 0/0/0", out_valid, count, in_ready); end
        total++; if (mem_csb0 !== 1'b1 || mem_csb1 !== 1'b1) begin bad++; $display("FAIL mid_csb got=%b%b want=11", mem_csb0, mem_csb1); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        step();
        total++; if (count !== 7'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_after count=%0d valid=%b want 0/0", count, out_valid); end
        in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 10 && got.size() == 0; n++) step();
        out_ready = 1'b0;
        total++; if (got.size() == 0 || got[0] !== 32'h5) begin
            bad++; $display("FAIL mid_first_word got_n=%0d got=%h want=5", got.size(), (got.size() > 0) ? got[0] : 32'h0); end
        total++; if (spurious != 0 || count !== 7'd0) begin
            bad++; $display("FAIL mid_end spurious=%0d count=%0d want 0/0", spurious, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Single-clock FIFO controller that turns the 32x32 1w1r OpenRAM macro into a valid/ready stream buffer. It sits directly in front of the macro. It drives the write port (csb0/addr0/din0) from an upstream push interface and the read port (csb1/addr1) from pointer state. It captures dout1 into a 2-entry output buffer that presents first-word-fall-through data to a downstream pop interface. Total capacity is DEPTH+2 words.

## Interface
- DATA_WIDTH, 32, word width; equals macro width
- ADDR_WIDTH, 5, macro address width
- DEPTH, 1<<ADDR_WIDTH, SRAM words; fixed, not overridable
- CNT_WIDTH, ADDR_WIDTH+2, occupancy counter width
- clk  in  1  single clock; tie macro clk0 and clk1 to it
- rst_n  in  1  reset, asynchronous and active-low (already decided)
- in_valid  in  1  push request
- in_ready  out  1  push accepted when in_valid & in_ready at posedge
- in_data  in  DATA_WIDTH  push data
- out_valid  out  1  out_data valid
- out_ready  in  1  pop accepted when out_valid & out_ready at posedge
- out_data  out  DATA_WIDTH  head of FIFO
- count  out  CNT_WIDTH  words held: SRAM + in-flight + output buffer
- mem_csb0  out  1  macro write chip select, active low
- mem_addr0  out  ADDR_WIDTH  macro write address
- mem_din0  out  DATA_WIDTH  macro write data
- mem_csb1  out  1  macro read chip select, active low
- mem_addr1  out  ADDR_WIDTH  macro read address
- mem_dout1  in  DATA_WIDTH  macro read data

## Operation
- State:
  - wptr, rptr: ADDR_WIDTH bits, wrap modulo DEPTH
  - sram_cnt: 0..DEPTH
  - inflight: 1 bit
  - obuf: 2 entries with head index, obuf_cnt 0..2
- Push:
  - push = in_valid & in_ready, with in_ready = rst_n & (sram_cnt < DEPTH).
  - Drive mem_csb0 = ~push, mem_addr0 = wptr, mem_din0 = in_data combinationally.
  - On push: wptr++ and sram_cnt++.
- Read issue:
  - issue = (sram_cnt > 0) & ((obuf_cnt + inflight < 2) | pop), with pop = out_valid & out_ready.
  - Drive mem_csb1 = ~issue, mem_addr1 = rptr.
  - On issue: rptr++, sram_cnt--, inflight <= 1; otherwise inflight <= 0.
  - Simultaneous push and issue: sram_cnt is unchanged.
- Capture: when inflight is 1 at a posedge, write mem_dout1 into obuf at the tail.
- Pop:
  - out_valid = (obuf_cnt > 0); out_data = obuf[head], driven from registers.
  - On pop: head advances. A capture and a pop in the same cycle leave obuf_cnt unchanged.
- count = sram_cnt + inflight + obuf_cnt, registered.
- A same-address write and read in one cycle is impossible by construction: writes require sram_cnt < DEPTH and reads require sram_cnt > 0. Carry a simulation assertion that !push | !issue | (wptr != rptr).
- Full: in_ready=0 while sram_cnt==DEPTH, including a cycle with a concurrent issue (no write-through at full).
- Empty: out_valid=0; in_data is never bypassed around the SRAM.
- Reset, including mid-operation:
  - Clear pointers, counters, inflight and obuf; drop any in-flight read.
  - SRAM contents are left untouched and ignored.
  - While rst_n=0: in_ready=0, out_valid=0, count=0, mem_csb0=mem_csb1=1, addresses=0.

## Timing
- Macro samples csb/addr/din at posedge E. It writes at negedge E and drives dout1 at negedge E+DELAY. dout1 goes X T_HOLD after the next posedge.
- mem_dout1 is sampled only at posedge E+1 after an issue at E; never sample later.
- Latency from push accepted at E (empty FIFO) to out_valid high: after posedge E+2, i.e. 2 cycles.
- Throughput: one push and one pop per cycle sustained. The 2-entry obuf covers the 1-cycle read latency with out_ready held high.
- Backpressure: out_ready low stops issue once obuf_cnt + inflight == 2. An in-flight read always has a free obuf slot.
- in_ready depends only on registered state and rst_n; there is no combinational path from out_ready.

## Test plan
- Reset then idle:
  - count=0, out_valid=0, in_ready=1, mem_csb0=mem_csb1=1.
- Single word:
  - Push 0xDEADBEEF at edge E -> mem_csb0=0, mem_addr0=0 at E; mem_csb1=0, mem_addr1=0 at E+1.
  - out_valid=1 with out_data=0xDEADBEEF after E+2; pop -> count=0.
- Fill with out_ready=0:
  - Push 0..40 -> 34 words accepted, in_ready=0 with count=34; no X on out_data.
  - Drain -> values 0..33 in order.
- Streaming wrap:
  - 200 consecutive pushes with out_ready=1 -> 200 words in order.
  - Pointers wrap ≥6 times; no assertion fires; steady throughput is 1 word/cycle.
- Random backpressure:
  - 10k words, random in_valid/out_ready -> scoreboard matches; count always equals the model.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously with count=20 and a read in flight -> out_valid drops immediately.
  - After release: count=0; the next push of 0x5 is the first word popped.
